// File: rtl/icache_valid_array_if.sv
// Request/response bundle for the instruction-cache valid-bit array:
// read port, fill-write port, invalidate port and flush handshake.
interface icache_valid_array_if #(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned WAYS  = 2
);
  logic             ReadEn;
  logic [IDX_W-1:0] ReadIndex;
  logic [WAYS-1:0]  ValidOut;
  logic             WriteValid;
  logic [IDX_W-1:0] WriteIndex;
  logic [WAYS-1:0]  WriteWay;
  logic             Invalidate;
  logic [IDX_W-1:0] InvIndex;
  logic [WAYS-1:0]  InvWay;
  logic             FlushReq;
  logic             FlushBusy;
  logic             FlushDone;

  modport master (
    output ReadEn, ReadIndex, WriteValid, WriteIndex, WriteWay,
           Invalidate, InvIndex, InvWay, FlushReq,
    input  ValidOut, FlushBusy, FlushDone
  );

  modport slave (
    input  ReadEn, ReadIndex, WriteValid, WriteIndex, WriteWay,
           Invalidate, InvIndex, InvWay, FlushReq,
    output ValidOut, FlushBusy, FlushDone
  );
endinterface

// File: rtl/icache_valid_array.sv
// SETS x WAYS valid-bit array with registered read, fill/invalidate ports
// and a sequential whole-array flush (fence.i) engine.
module icache_valid_array #(
  parameter int unsigned SETS   = 128,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned BYPASS = 0
) (
  input  logic                clk,
  input  logic                Reset,
  icache_valid_array_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} flush_state_e;

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [WAYS-1:0]  valid_out_q, valid_out_d;
  logic             busy;

  assign busy          = (state_q != IDLE);
  assign bus.ValidOut  = valid_out_q;
  assign bus.FlushBusy = busy;
  assign bus.FlushDone = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    valid_d     = valid_q;
    valid_out_d = valid_out_q;

    case (state_q)
      IDLE: begin
        if (bus.FlushReq) begin
          state_d     = RUN;
          flush_idx_d = '0;
        end
      end
      RUN: begin
        valid_d[flush_idx_q] = '0;
        flush_idx_d          = flush_idx_q + 1'b1;
        if (flush_idx_q == IDX_W'(SETS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Invalidate is applied after the write so it wins on overlapping bits.
    if (!busy) begin
      if (bus.WriteValid)
        valid_d[bus.WriteIndex] = valid_d[bus.WriteIndex] | bus.WriteWay;
      if (bus.Invalidate)
        valid_d[bus.InvIndex] = valid_d[bus.InvIndex] & ~bus.InvWay;
    end

    if (bus.ReadEn) begin
      if (busy)
        valid_out_d = '0;
      else if (BYPASS != 0)
        valid_out_d = valid_d[bus.ReadIndex];
      else
        valid_out_d = valid_q[bus.ReadIndex];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      valid_out_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      valid_out_q <= valid_out_d;
      valid_q     <= valid_d;
    end
  end
endmodule

// File: tb/tb_icache_valid_array.sv
// Directed bench for icache_valid_array: one BYPASS=0 and one BYPASS=1 copy
// driven with identical stimulus.
module tb_icache_valid_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  icache_valid_array_if #(.IDX_W(7), .WAYS(2)) bus0 ();
  icache_valid_array_if #(.IDX_W(7), .WAYS(2)) bus1 ();

  assign bus1.ReadEn     = bus0.ReadEn;
  assign bus1.ReadIndex  = bus0.ReadIndex;
  assign bus1.WriteValid = bus0.WriteValid;
  assign bus1.WriteIndex = bus0.WriteIndex;
  assign bus1.WriteWay   = bus0.WriteWay;
  assign bus1.Invalidate = bus0.Invalidate;
  assign bus1.InvIndex   = bus0.InvIndex;
  assign bus1.InvWay     = bus0.InvWay;
  assign bus1.FlushReq   = bus0.FlushReq;

  icache_valid_array #(.SETS(128), .WAYS(2), .BYPASS(0)) u_dut (
    .clk(clk), .Reset(rst), .bus(bus0)
  );
  icache_valid_array #(.SETS(128), .WAYS(2), .BYPASS(1)) u_dut_byp (
    .clk(clk), .Reset(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    bus0.ReadEn = 1'b0; bus0.ReadIndex = '0;
    bus0.WriteValid = 1'b0; bus0.WriteIndex = '0; bus0.WriteWay = '0;
    bus0.Invalidate = 1'b0; bus0.InvIndex = '0; bus0.InvWay = '0;
    bus0.FlushReq = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] idx);
    bus0.ReadEn = 1'b1; bus0.ReadIndex = idx;
    tick();
    clear();
  endtask

  task automatic wr(input logic [6:0] idx, input logic [1:0] way);
    bus0.WriteValid = 1'b1; bus0.WriteIndex = idx; bus0.WriteWay = way;
    tick();
    clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int n;
    clear();
    #12;
    chk("rst_validout", {6'b0, bus0.ValidOut}, 8'h00);
    chk("rst_busy", {7'b0, bus0.FlushBusy}, 8'h00);
    chk("rst_done", {7'b0, bus0.FlushDone}, 8'h00);
    tick(); tick();
    rst = 1'b0;

    // Freshly reset reads
    rd(7'd0);   chk("rd0_after_rst",   {6'b0, bus0.ValidOut}, 8'h00);
    rd(7'd5);   chk("rd5_after_rst",   {6'b0, bus0.ValidOut}, 8'h00);
    rd(7'd127); chk("rd127_after_rst", {6'b0, bus0.ValidOut}, 8'h00);

    // Fill writes accumulate per way
    wr(7'd5, 2'b10);
    rd(7'd5); chk("rd5_way1", {6'b0, bus0.ValidOut}, 8'h02);
    wr(7'd5, 2'b01);
    rd(7'd5); chk("rd5_both", {6'b0, bus0.ValidOut}, 8'h03);

    // ValidOut holds with ReadEn=0 while the set changes underneath
    bus0.Invalidate = 1'b1; bus0.InvIndex = 7'd5; bus0.InvWay = 2'b01;
    tick(); clear();
    chk("hold_noread", {6'b0, bus0.ValidOut}, 8'h03);
    rd(7'd5); chk("rd5_after_inv", {6'b0, bus0.ValidOut}, 8'h02);

    // Same-cycle write+invalidate+read of set 9, way 0
    wr(7'd9, 2'b01);
    bus0.WriteValid = 1'b1; bus0.WriteIndex = 7'd9; bus0.WriteWay = 2'b01;
    bus0.Invalidate = 1'b1; bus0.InvIndex = 7'd9;   bus0.InvWay = 2'b01;
    bus0.ReadEn = 1'b1;     bus0.ReadIndex = 7'd9;
    tick(); clear();
    chk("conflict_nobyp", {6'b0, bus0.ValidOut}, 8'h01);
    chk("conflict_byp",   {6'b0, bus1.ValidOut}, 8'h00);
    rd(7'd9);
    chk("conflict_later_nobyp", {6'b0, bus0.ValidOut}, 8'h00);
    chk("conflict_later_byp",   {6'b0, bus1.ValidOut}, 8'h00);

    // Non-overlapping write and invalidate both land
    bus0.WriteValid = 1'b1; bus0.WriteIndex = 7'd9; bus0.WriteWay = 2'b10;
    bus0.Invalidate = 1'b1; bus0.InvIndex = 7'd5;   bus0.InvWay = 2'b10;
    tick(); clear();
    rd(7'd9); chk("split_wr9", {6'b0, bus0.ValidOut}, 8'h02);
    rd(7'd5); chk("split_inv5", {6'b0, bus0.ValidOut}, 8'h00);
    bus0.WriteValid = 1'b1; bus0.WriteIndex = 7'd9; bus0.WriteWay = 2'b01;
    bus0.Invalidate = 1'b1; bus0.InvIndex = 7'd9;   bus0.InvWay = 2'b10;
    tick(); clear();
    rd(7'd9); chk("same_set_diff_way", {6'b0, bus0.ValidOut}, 8'h01);

    // Full fill, then flush with a redundant request, a read and a write while busy
    for (int s = 0; s < 128; s++) wr(7'(s), 2'b11);
    rd(7'd127); chk("rd127_filled", {6'b0, bus0.ValidOut}, 8'h03);
    bus0.FlushReq = 1'b1;
    tick(); clear();
    for (int c = 1; c <= 130; c++) begin
      chk($sformatf("flush_busy_c%0d", c), {7'b0, bus0.FlushBusy}, (c <= 129) ? 8'h01 : 8'h00);
      chk($sformatf("flush_done_c%0d", c), {7'b0, bus0.FlushDone}, (c == 129) ? 8'h01 : 8'h00);
      if (c == 4) chk("hold_before_busy_read", {6'b0, bus0.ValidOut}, 8'h03);
      if (c == 5) chk("busy_read_zero", {6'b0, bus0.ValidOut}, 8'h00);
      if (c == 4)  begin bus0.ReadEn = 1'b1; bus0.ReadIndex = 7'd127; end
      if (c == 10) bus0.FlushReq = 1'b1;
      if (c == 20) begin bus0.WriteValid = 1'b1; bus0.WriteIndex = 7'd1; bus0.WriteWay = 2'b11; end
      tick(); clear();
    end
    for (int s = 0; s < 128; s++) begin
      rd(7'(s));
      chk($sformatf("post_flush_set%0d", s), {6'b0, bus0.ValidOut}, 8'h00);
    end

    // Write coincident with FlushReq lands, then gets flushed
    bus0.WriteValid = 1'b1; bus0.WriteIndex = 7'd7; bus0.WriteWay = 2'b10;
    bus0.ReadEn = 1'b1;     bus0.ReadIndex = 7'd7;
    bus0.FlushReq = 1'b1;
    tick(); clear();
    chk("wr_flush_nobyp", {6'b0, bus0.ValidOut}, 8'h00);
    chk("wr_flush_byp",   {6'b0, bus1.ValidOut}, 8'h02);
    chk("wr_flush_busy",  {7'b0, bus0.FlushBusy}, 8'h01);
    n = 0;
    while (!bus0.FlushDone && n < 300) begin tick(); n++; end
    chk("wr_flush_done_seen", {7'b0, bus0.FlushDone}, 8'h01);
    tick();
    rd(7'd7); chk("wr_flush_cleared", {6'b0, bus1.ValidOut}, 8'h00);

    // Reset in the middle of a flush
    wr(7'd100, 2'b11);
    wr(7'd3, 2'b01);
    rd(7'd100); chk("rd100_before_abort", {6'b0, bus0.ValidOut}, 8'h03);
    bus0.FlushReq = 1'b1;
    tick(); clear();
    for (int k = 0; k < 49; k++) tick();
    chk("abort_busy_before", {7'b0, bus0.FlushBusy}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",     {7'b0, bus0.FlushBusy}, 8'h00);
    chk("abort_done",     {7'b0, bus0.FlushDone}, 8'h00);
    chk("abort_validout", {6'b0, bus0.ValidOut},  8'h00);
    tick(); tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus0.FlushDone || bus0.FlushBusy) dones++;
      tick();
    end
    chk("abort_no_done_pulse", 8'(dones), 8'h00);
    rd(7'd100); chk("abort_set100_clear", {6'b0, bus0.ValidOut}, 8'h00);
    rd(7'd3);   chk("abort_set3_clear",   {6'b0, bus0.ValidOut}, 8'h00);
    wr(7'd100, 2'b01);
    rd(7'd100); chk("abort_wr_rd",     {6'b0, bus0.ValidOut}, 8'h01);
    chk("abort_wr_rd_byp", {6'b0, bus1.ValidOut}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
